// File: rtl/btn_step_pulse.sv
// btn_step_pulse: debounces one raw push-button and emits a single-cycle STEP
// pulse per accepted press, plus the debounced LEVEL and a BUSY flag while a
// level change is being qualified.
// Optional feature macro: AUTO_REPEAT_EN (held button generates repeat STEPs).
// With AUTO_REPEAT_EN undefined no repeat logic exists and PRESSED holds cnt=0.
module btn_step_pulse #(
  parameter int unsigned DEB_CYCLES    = 32'd50000,
  parameter int unsigned REPEAT_DELAY  = 32'd25000000,
  parameter int unsigned REPEAT_PERIOD = 32'd10000000,
  parameter int unsigned CNT_W         = $clog2(
      (DEB_CYCLES > REPEAT_DELAY)
        ? ((DEB_CYCLES > REPEAT_PERIOD) ? DEB_CYCLES : REPEAT_PERIOD)
        : ((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD)) + 1
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic BTN,
  output logic STEP,
  output logic LEVEL,
  output logic BUSY
);

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_DEB   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_DEB = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 32'd1);

  logic [1:0]       sync_q;
  logic             btn_s;
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             step_q;
  logic             level_q;
  logic             busy_q;

`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] RPT_DELAY_LAST  = CNT_W'(REPEAT_DELAY - 32'd1);
  localparam logic [CNT_W-1:0] RPT_PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 32'd1);
  // Set once the first (long) repeat delay has elapsed in the current hold.
  logic             rpt_first_q;
`endif

  // Two-flop synchronizer: the raw pin is asynchronous to CLK.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], BTN};
    end
  end

  assign btn_s = sync_q[1];

  // Debounce FSM with shared counter; STEP, LEVEL and BUSY registered here.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= RELEASED;
      cnt_q       <= '0;
      step_q      <= 1'b0;
      level_q     <= 1'b0;
      busy_q      <= 1'b0;
`ifdef AUTO_REPEAT_EN
      rpt_first_q <= 1'b0;
`endif
    end else begin
      step_q <= 1'b0;
      case (state_q)
        RELEASED: begin
          if (btn_s) begin
            state_q <= PRESS_DEB;
            cnt_q   <= CNT_ONE;
            busy_q  <= 1'b1;
          end else begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end
        end

        PRESS_DEB: begin
          if (!btn_s) begin
            // A bounce throws away all qualification progress.
            state_q <= RELEASED;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_q == DEB_LAST) begin
            state_q     <= PRESSED;
            level_q     <= 1'b1;
            step_q      <= 1'b1;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
`ifdef AUTO_REPEAT_EN
            rpt_first_q <= 1'b0;
`endif
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        PRESSED: begin
          if (!btn_s) begin
            state_q     <= RELEASE_DEB;
            cnt_q       <= CNT_ONE;
            busy_q      <= 1'b1;
`ifdef AUTO_REPEAT_EN
            rpt_first_q <= 1'b0;
`endif
          end else begin
`ifdef AUTO_REPEAT_EN
            // cnt counts held cycles; first repeat after the long delay,
            // later ones every period. Restarting at 0 keeps pulses apart.
            if (!rpt_first_q && (cnt_q == RPT_DELAY_LAST)) begin
              step_q      <= 1'b1;
              cnt_q       <= '0;
              rpt_first_q <= 1'b1;
            end else if (rpt_first_q && (cnt_q == RPT_PERIOD_LAST)) begin
              step_q <= 1'b1;
              cnt_q  <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
`else
            cnt_q <= '0;
`endif
          end
        end

        RELEASE_DEB: begin
          if (btn_s) begin
            // Release bounce: the press is still valid, no new STEP.
            state_q <= PRESSED;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_q == DEB_LAST) begin
            state_q <= RELEASED;
            level_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        default: begin
          state_q <= RELEASED;
          cnt_q   <= '0;
          level_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign STEP  = step_q;
  assign LEVEL = level_q;
  assign BUSY  = busy_q;

endmodule

// File: tb/tb_btn_step_pulse.sv
// Self-checking bench for btn_step_pulse: directed scenarios plus random
// button traffic, compared cycle by cycle against a run-length reference model.
module tb_btn_step_pulse;

  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RP  = 3;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  logic BTN   = 1'b0;
  logic STEP;
  logic LEVEL;
  logic BUSY;

  btn_step_pulse #(
    .DEB_CYCLES   (DEB),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .BTN  (BTN),
    .STEP (STEP),
    .LEVEL(LEVEL),
    .BUSY (BUSY)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Reference model: a level flips after DEB consecutive synchronized samples
  // that disagree with it; the synchronized value lags the pin by two edges.
  logic m_s1 = 1'b0, m_s2 = 1'b0;
  logic m_level = 1'b0;
  logic m_step = 1'b0;
  int   m_run = 0;
  int   m_hold = 0;
  bit   m_first = 1'b0;
  int   m_steps = 0;

  int   edge_no = 0;
  int   step_seen = 0;
  int   first_step_edge = -1;
  int   last_step_edge = -1;
  int   fall_count = 0;
  int   last_fall_edge = -1;
  int   busy_seen = 0;
  logic prev_level = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = 1'b0; m_s2 = 1'b0; m_level = 1'b0; m_step = 1'b0;
    m_run = 0; m_hold = 0; m_first = 1'b0;
  endtask

  task automatic model_step(input logic b);
    logic bs;
    bit   was_pressed;
    if (!RST_N) begin
      model_reset();
    end else begin
      bs = m_s2;
      was_pressed = m_level && (m_run == 0);
      m_step = 1'b0;
      if (bs != m_level) begin
        m_run++;
        if (m_run == DEB) begin
          m_level = bs;
          m_run = 0;
          if (bs) m_step = 1'b1;
        end
      end else begin
        m_run = 0;
      end
`ifdef AUTO_REPEAT_EN
      if (was_pressed && bs) begin
        m_hold++;
        if (!m_first && m_hold == RD) begin
          m_step = 1'b1; m_hold = 0; m_first = 1'b1;
        end else if (m_first && m_hold == RP) begin
          m_step = 1'b1; m_hold = 0;
        end
      end else begin
        m_hold = 0; m_first = 1'b0;
      end
`else
      if (was_pressed) m_hold = 0;
`endif
      if (m_step) m_steps++;
      m_s2 = m_s1;
      m_s1 = b;
    end
  endtask

  // One clock: drive at the falling edge, model at the rising edge, compare
  // at the next falling edge.
  task automatic tick(input logic b);
    BTN = b;
    @(posedge CLK);
    edge_no++;
    model_step(b);
    @(negedge CLK);
    if (STEP === 1'b1) begin
      step_seen++;
      if (first_step_edge < 0) first_step_edge = edge_no;
      last_step_edge = edge_no;
    end
    if (prev_level === 1'b1 && LEVEL === 1'b0) begin
      fall_count++;
      last_fall_edge = edge_no;
    end
    prev_level = LEVEL;
    if (BUSY === 1'b1) busy_seen++;
    check_eq("step",  STEP,  m_step);
    check_eq("level", LEVEL, m_level);
    check_eq("busy",  BUSY,  (m_run != 0));
  endtask

  task automatic assert_reset();
    #2 RST_N = 1'b0;
    #1;
    check_eq("rst_step",  STEP,  1'b0);
    check_eq("rst_level", LEVEL, 1'b0);
    check_eq("rst_busy",  BUSY,  1'b0);
    model_reset();
  endtask

  task automatic clear_obs();
    step_seen = 0; first_step_edge = -1; last_step_edge = -1;
    fall_count = 0; last_fall_edge = -1; busy_seen = 0;
  endtask

  int k;
  int len;
  logic b;

  initial begin
    // Reset with the button held high: outputs low without any clock edge.
    BTN = 1'b1;
    RST_N = 1'b0;
    #1;
    check_eq("init_step",  STEP,  1'b0);
    check_eq("init_level", LEVEL, 1'b0);
    check_eq("init_busy",  BUSY,  1'b0);
    repeat (3) @(negedge CLK);
    BTN = 1'b0;
    RST_N = 1'b1;
    repeat (4) tick(1'b0);

    // Clean press and release with exact latency.
    clear_obs();
    k = edge_no + 1;
    repeat (20) tick(1'b1);
    check_eq("press_lat", first_step_edge - k, DEB + 1);
    check_eq("press_cnt", step_seen, 1);
    k = edge_no + 1;
    repeat (12) tick(1'b0);
    check_eq("rel_lat", last_fall_edge - k, DEB + 1);
    check_eq("rel_steps", step_seen, 1);

    // Short bursts never qualify but do show BUSY.
    clear_obs();
    repeat (3) tick(1'b1);
    tick(1'b0);
    repeat (3) tick(1'b1);
    repeat (8) tick(1'b0);
    check_eq("bounce_steps", step_seen, 0);
    check_eq("bounce_busy", (busy_seen > 0), 1'b1);

    // Release bounce: one press, one fall.
    clear_obs();
    repeat (10) tick(1'b1);
    repeat (2) tick(1'b0);
    tick(1'b1);
    repeat (10) tick(1'b0);
    check_eq("relb_steps", step_seen, 1);
    check_eq("relb_falls", fall_count, 1);

    // Reset mid-hold: button still held is requalified and steps again.
    clear_obs();
    repeat (8) tick(1'b1);
    assert_reset();
    repeat (2) tick(1'b1);
    RST_N = 1'b1;
    k = edge_no + 1;
    repeat (10) tick(1'b1);
    check_eq("rsthold_steps", step_seen, 2);
    check_eq("rsthold_lat", last_step_edge - k, DEB + 1);
    repeat (10) tick(1'b0);

    // Long hold: one STEP without auto-repeat, model-defined with it.
    clear_obs();
    m_steps = 0;
    repeat (DEB + 2 + 30) tick(1'b1);
    repeat (10) tick(1'b0);
    check_eq("hold_steps_model", step_seen, m_steps);
`ifndef AUTO_REPEAT_EN
    check_eq("hold_steps_one", step_seen, 1);
`endif

    // Random traffic: mostly short bounces, some qualifying holds, rare resets.
    clear_obs();
    m_steps = 0;
    for (int i = 0; i < 250; i++) begin
      b = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) len = $urandom_range(DEB, 3 * DEB + 14);
      else len = $urandom_range(1, DEB + 1);
      repeat (len) tick(b);
      if ($urandom_range(0, 40) == 0) begin
        assert_reset();
        tick(b);
        RST_N = 1'b1;
      end
    end
    repeat (12) tick(1'b0);
    check_eq("rand_steps", step_seen, m_steps);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
